mio_bus_arbiter: RTL and testbench
==================================

// Module: mio_bus_arbiter
// PURPOSE
//  Shares the single MIO/data-memory bus between the pipelined CPU's MEM-stage port and a debug/DMA port.
//  Two-way round-robin grant; each transaction is held until the bus returns ready (the MIO_ready handshake)
//  or a timeout fires. Drives the stall that freezes the CPU pipeline while its access is pending.
//  Sits between the CPU top level (mem_w/Addr_out/Data_out/DMType/Data_in) and the memory/peripheral bus.
// PARAMETERS
//  TIMEOUT_CYCLES  255           bus-busy cycles before a forced error completion (1..2^CNT_W-1)
//  CNT_W           8             width of the timeout counter
//  ERR_DATA        32'hDEAD_BEEF read data returned on a timed-out transaction
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  cpu_req    in   1   CPU MEM stage holds a load or store
//  cpu_we     in   1   1 = store
//  cpu_dmtype in   3   byte/half/word + sign code, passed through unchanged
//  cpu_addr   in   32  byte address
//  cpu_wdata  in   32  store data
//  cpu_rdata  out  32  load data, valid in the cycle cpu_stall falls
//  cpu_stall  out  1   freeze CPU pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//  dbg_req    in   1   debug/DMA request, held until dbg_ack
//  dbg_we     in   1   1 = write
//  dbg_addr   in   32  word address (word access only)
//  dbg_wdata  in   32  write data
//  dbg_rdata  out  32  registered read data, valid with dbg_ack
//  dbg_ack    out  1   one-cycle completion pulse
//  bus_req    out  1   transaction active on bus
//  bus_we     out  1   write strobe
//  bus_dmtype out  3   access type (dbg forces word code)
//  bus_addr   out  32  address
//  bus_wdata  out  32  write data
//  bus_rdata  in   32  read data from memory/MIO
//  bus_ready  in   1   bus completes current transaction this cycle
//  bus_owner  out  1   0 = CPU, 1 = debug (valid while bus_req)
//  bus_err    out  1   one-cycle pulse: transaction ended by timeout
// BEHAVIOUR
//  - Reset: state IDLE, last_owner=1 (CPU wins first tie), all outputs 0, timeout counter 0.
//  - FSM: IDLE -> BUSY_CPU | BUSY_DBG on grant; BUSY_x -> IDLE on bus_ready or timeout.
//  - Grant in IDLE: single requester wins; both -> requester != last_owner. last_owner updates at grant.
//  - At grant, requester's we/dmtype/addr/wdata are latched; bus_* driven from the latch only in BUSY_x.
//  - bus_req=1 exactly while in BUSY_x; latched fields stable for the whole transaction.
//  - Completion: bus_ready=1 in BUSY_x ends the transaction that cycle (min latency 2 cycles from req to done).
//  - Timeout: counter increments each BUSY cycle without bus_ready; at TIMEOUT_CYCLES complete with
//    read data ERR_DATA, bus_err pulse; stores are dropped. Counter clears on every grant.
//  - cpu_stall = cpu_req & ~(state==BUSY_CPU & (bus_ready | timeout)); combinational.
//  - cpu_rdata = bus_rdata (or ERR_DATA on timeout) in completion cycle, else 0.
//  - dbg_ack/dbg_rdata registered: asserted the cycle after BUSY_DBG completes; dbg_rdata holds until next ack.
//  - Always one IDLE cycle between transactions; max throughput 1 transaction / 2 cycles.
//  - Requester drop after grant is ignored; transaction completes, no ack to a withdrawn dbg request is an error
//    on the requester side, not the arbiter's.
//  - bus_ready while IDLE: ignored.
//  - rst mid-transaction: next cycle IDLE, bus_req=0, transaction abandoned, no ack/err pulse.
// STRUCTURE
//  - Shared header (alongside ctrl_encode_def.v): FSM state encodings, DMType word code constant.
//  - One sub-module: arb_rr2 (2-way round-robin picker: req[1:0], last_owner -> gnt, owner).
//  - Latches and timeout counter built from GRE_array-style registers with write_enable.
// TESTING
//  - CPU load alone: cpu_req=1 addr=0x100, bus_ready=1 in first BUSY cycle -> stall high 1 cycle, cpu_rdata=bus_rdata.
//  - Simultaneous cpu_req+dbg_req after reset -> CPU first, then dbg; dbg_ack 1 cycle after dbg completion.
//  - Both requesters held continuously -> grants alternate CPU, dbg, CPU, dbg.
//  - bus_ready held low, TIMEOUT_CYCLES=4 -> completion after 4 BUSY cycles, bus_err pulse, rdata=0xDEADBEEF.
//  - Dbg write 0x1234_5678 to 0x40, bus_ready after 3 cycles -> bus_we=1, bus_dmtype=word, fields stable throughout.
//  - rst asserted in 2nd BUSY cycle -> bus_req=0 next cycle, no dbg_ack, new request granted normally after.

Source files
------------

// File: rtl/mio_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mio_bus_arbiter_pkg
// Shared definitions for the MIO bus arbiter: FSM state encoding, owner codes,
// the DMType code for a full-word access, and the two-way round-robin pick
// used by arb_rr2.
// -----------------------------------------------------------------------------
package mio_bus_arbiter_pkg;

    // Arbiter FSM states: one idle state plus one busy state per bus owner.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_BUSY_CPU = 2'b01,
        ST_BUSY_DBG = 2'b10
    } arb_state_t;

    // Owner codes as seen on bus_owner and stored in last_owner.
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    // DMType code for a 32-bit word access (same code as dm_word in
    // ctrl_encode_def.v). Debug/DMA accesses always use this code.
    localparam logic [2:0] DM_WORD = 3'b000;

    // Round-robin pick between the CPU (req[0]) and debug (req[1]) ports.
    // On a tie the port that did not win last time gets the bus.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_owner);
        logic owner;
        owner = OWNER_CPU;
        case (req)
            2'b01:   owner = OWNER_CPU;
            2'b10:   owner = OWNER_DBG;
            2'b11:   owner = ~last_owner;
            default: owner = OWNER_CPU;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/mio_bus_arbiter_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-way round-robin picker, purely combinational.
// Ports:
//   req[1:0]    in   request vector, bit 0 = CPU, bit 1 = debug/DMA
//   last_owner  in   owner of the most recent grant (0 = CPU, 1 = debug)
//   gnt[1:0]    out  one-hot grant, all zero when nobody requests
//   owner       out  winning owner code (meaningful only when |gnt)
// -----------------------------------------------------------------------------
module arb_rr2
    import mio_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt,
    output logic       owner
);

    // Pick the winner, then turn it into a one-hot grant only if someone asked.
    always_comb begin
        owner = rr_pick(req, last_owner);
        gnt   = 2'b00;
        if (|req) begin
            gnt = (owner == OWNER_DBG) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mio_bus_arbiter
// Shares the single MIO/data-memory bus between the CPU MEM stage and a
// debug/DMA port. Round-robin grant, one transaction at a time, each held
// until bus_ready or until the timeout counter expires. Freezes the CPU
// pipeline while its access is pending.
//
// Parameters:
//   TIMEOUT_CYCLES  busy cycles without bus_ready before a forced completion
//   CNT_W           width of the timeout counter
//   ERR_DATA        read data returned by a timed-out transaction
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/dmtype/addr/wdata CPU MEM-stage access (byte address)
//   cpu_rdata                    load data, valid in the cycle cpu_stall falls
//   cpu_stall                    pipeline freeze while the CPU access is pending
//   dbg_req/we/addr/wdata        debug/DMA word access, req held until dbg_ack
//   dbg_rdata, dbg_ack           registered read data and one-cycle ack
//   bus_req/we/dmtype/addr/wdata bus side of the granted transaction
//   bus_rdata, bus_ready         bus response
//   bus_owner                    0 = CPU, 1 = debug, valid while bus_req
//   bus_err                      one-cycle pulse when a transaction times out
//
// dbg_ack arrives in the IDLE cycle that follows a debug completion, so a
// debug requester must drop (or replace) dbg_req in the ack cycle; a request
// still standing then is taken as a new transaction.
// -----------------------------------------------------------------------------
module mio_bus_arbiter
    import mio_bus_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_dmtype,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,

    output logic        bus_req,
    output logic        bus_we,
    output logic [2:0]  bus_dmtype,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_owner,
    output logic        bus_err
);

    // Counter value seen in the last allowed busy cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    arb_state_t       next_state;
    logic             last_owner;

    logic             lat_we;
    logic [2:0]       lat_dmtype;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [CNT_W-1:0] tmo_cnt;

    logic [1:0]       gnt;
    logic             gnt_owner;
    logic             grant;
    logic             busy;
    logic             timeout;
    logic             done;
    logic [31:0]      done_data;

    arb_rr2 u_rr2 (
        .req        ({dbg_req, cpu_req}),
        .last_owner (last_owner),
        .gnt        (gnt),
        .owner      (gnt_owner)
    );

    // Transaction status. bus_ready wins over the timeout when both land in
    // the same cycle, so a late but valid response is never reported as an
    // error.
    always_comb begin
        busy      = (state != ST_IDLE);
        grant     = (state == ST_IDLE) && (gnt != 2'b00);
        timeout   = busy && !bus_ready && (tmo_cnt == TMO_LAST);
        done      = busy && (bus_ready || timeout);
        done_data = bus_ready ? bus_rdata : ERR_DATA;
    end

    // Next-state logic: grant from IDLE, return to IDLE on completion. The
    // forced return through IDLE gives the other port a chance every time.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    next_state = (gnt_owner == OWNER_DBG) ? ST_BUSY_DBG : ST_BUSY_CPU;
                end
            end
            ST_BUSY_CPU,
            ST_BUSY_DBG: begin
                if (done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Bus side is driven only from the latched request and only while busy,
    // so requester changes after the grant never reach the bus. The CPU sees
    // its load data and the stall release in the completion cycle itself.
    always_comb begin
        bus_req    = busy;
        bus_we     = 1'b0;
        bus_dmtype = 3'b000;
        bus_addr   = 32'h0;
        bus_wdata  = 32'h0;
        bus_owner  = (state == ST_BUSY_DBG);
        bus_err    = timeout;
        cpu_rdata  = 32'h0;
        cpu_stall  = cpu_req;
        if (busy) begin
            bus_we     = lat_we;
            bus_dmtype = lat_dmtype;
            bus_addr   = lat_addr;
            bus_wdata  = lat_wdata;
        end
        if ((state == ST_BUSY_CPU) && done) begin
            cpu_rdata = done_data;
            cpu_stall = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Round-robin history; resets to debug so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWNER_DBG;
        end else if (grant) begin
            last_owner <= gnt_owner;
        end
    end

    // Request latch, written only at grant. Debug accesses are always words.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we     <= 1'b0;
            lat_dmtype <= 3'b000;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
        end else if (grant) begin
            if (gnt_owner == OWNER_DBG) begin
                lat_we     <= dbg_we;
                lat_dmtype <= DM_WORD;
                lat_addr   <= dbg_addr;
                lat_wdata  <= dbg_wdata;
            end else begin
                lat_we     <= cpu_we;
                lat_dmtype <= cpu_dmtype;
                lat_addr   <= cpu_addr;
                lat_wdata  <= cpu_wdata;
            end
        end
    end

    // Timeout counter: cleared at every grant, counts busy cycles without a
    // response and stops once the timeout has fired.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (grant) begin
            tmo_cnt <= '0;
        end else if (busy && !bus_ready && !timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Debug completion is reported one cycle late from registers; the read
    // data stays put until the next debug completion overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_ack   <= 1'b0;
            dbg_rdata <= 32'h0;
        end else begin
            dbg_ack <= (state == ST_BUSY_DBG) && done;
            if ((state == ST_BUSY_DBG) && done) begin
                dbg_rdata <= done_data;
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_arbiter
// Scoreboard bench for mio_bus_arbiter. Requests are queued per port and the
// expected bus transaction for each is queued in grant order; a bus responder
// answers after a programmable number of busy cycles, and a monitor on the
// falling edge pops and compares every transaction and every cycle's outputs.
// -----------------------------------------------------------------------------
module tb_mio_bus_arbiter;
    import mio_bus_arbiter_pkg::*;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [2:0]  cpu_dmtype = 3'b000;
    logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        bus_req, bus_we, bus_owner, bus_err;
    logic [2:0]  bus_dmtype;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ready = 1'b0;

    mio_bus_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (8),
        .ERR_DATA       (ERR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_dmtype (cpu_dmtype),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_dmtype (bus_dmtype),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .bus_owner  (bus_owner),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [2:0]  dmtype;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [2:0]  dmtype;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    req_t        cpu_q[$];
    req_t        dbg_q[$];
    exp_t        exp_q[$];

    int          checks = 0;
    int          failures = 0;
    int          ready_delay = 0;
    logic        idle_ready = 1'b0;
    logic        abort_ok = 1'b0;

    exp_t        cur = '0;
    logic        txn_open = 1'b0;
    int          busy_idx = 0;
    int          resp_idx = 0;
    int          grants = 0;
    logic        prev_bus_req = 1'b0;
    logic        ack_due = 1'b0;
    logic [31:0] ack_data = 32'h0;
    logic [31:0] held_rdata = 32'h0;

    // Memory contents seen by the bus responder.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
        end
    endtask

    // Queue a request on one port and its expected bus transaction. Calls are
    // made in the order the grants are expected to happen.
    task automatic applyStimulus(input logic owner, input logic we, input logic [2:0] dmtype,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        exp_t e;
        r.we     = we;
        r.dmtype = dmtype;
        r.addr   = addr;
        r.wdata  = wdata;
        e.owner  = owner;
        e.we     = we;
        e.dmtype = (owner == OWNER_DBG) ? DM_WORD : dmtype;
        e.addr   = addr;
        e.wdata  = wdata;
        e.err    = (ready_delay >= TMO);
        e.rdata  = e.err ? ERR : mem_model(addr);
        exp_q.push_back(e);
        if (owner == OWNER_DBG) dbg_q.push_back(r);
        else                    cpu_q.push_back(r);
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2;
        rst        = 1'b1;
        abort_ok   = 1'b1;
        ack_due    = 1'b0;
        held_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #2;
        rst      = 1'b0;
        abort_ok = 1'b0;
        @(negedge clk);
        #3;
        checkOutput("rst_bus", 128'({bus_req, bus_we, bus_dmtype, bus_addr, bus_wdata, bus_owner, bus_err}), 128'(0));
        checkOutput("rst_cpu", 128'({cpu_stall, cpu_rdata}), 128'(0));
        checkOutput("rst_dbg", 128'({dbg_ack, dbg_rdata}), 128'(0));
    endtask

    // Wait until every queued request has been granted, completed and acked.
    task automatic waitIdle(input int budget);
        int n;
        int pending;
        n = 0;
        pending = 1;
        while (pending != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
            pending = exp_q.size() + cpu_q.size() + dbg_q.size()
                    + int'(txn_open) + int'(ack_due) + int'(cpu_req) + int'(dbg_req);
        end
        checkOutput("drain", 128'(pending), 128'(0));
    endtask

    // Bus responder, then monitor/scoreboard, then requester agents.
    always @(negedge clk) begin
        logic cpu_done;
        logic dbg_done;
        logic done;
        logic ack_now;
        req_t r;

        if (bus_req) begin
            bus_ready = (resp_idx == ready_delay);
            bus_rdata = mem_model(bus_addr);
            resp_idx++;
        end else begin
            resp_idx  = 0;
            bus_ready = idle_ready;
            bus_rdata = 32'h0BAD_0BAD;
        end

        #1;
        cpu_done = 1'b0;
        dbg_done = 1'b0;
        done     = 1'b0;
        ack_now  = 1'b0;

        if (bus_req) begin
            if (!txn_open) begin
                checkOutput("idle_gap", 128'(prev_bus_req), 128'(0));
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_grant", 128'(bus_req), 128'(0));
                end else begin
                    cur      = exp_q.pop_front();
                    txn_open = 1'b1;
                    busy_idx = 0;
                    grants++;
                end
            end
            if (txn_open) begin
                checkOutput("bus_fields",
                            128'({bus_owner, bus_we, bus_dmtype, bus_addr, bus_wdata}),
                            128'({cur.owner, cur.we, cur.dmtype, cur.addr, cur.wdata}));
                done = cur.err ? (busy_idx == TMO - 1) : (busy_idx == ready_delay);
                checkOutput("bus_err", 128'(bus_err), 128'(done && cur.err));
                if (done) begin
                    if (cur.owner == OWNER_DBG) dbg_done = 1'b1;
                    else                        cpu_done = 1'b1;
                    txn_open = 1'b0;
                end
                busy_idx++;
            end
        end else begin
            if (txn_open) begin
                checkOutput("abandon", 128'(abort_ok), 128'(1));
                txn_open = 1'b0;
            end
            checkOutput("idle_err", 128'(bus_err), 128'(0));
        end

        checkOutput("cpu_stall", 128'(cpu_stall), 128'(cpu_req && !cpu_done));
        checkOutput("cpu_rdata", 128'(cpu_rdata), 128'(cpu_done ? cur.rdata : 32'h0));

        if (ack_due) begin
            checkOutput("dbg_ack", 128'(dbg_ack), 128'(1));
            checkOutput("dbg_rdata", 128'(dbg_rdata), 128'(ack_data));
            held_rdata = ack_data;
            ack_due    = 1'b0;
            ack_now    = 1'b1;
        end else begin
            checkOutput("dbg_ack_idle", 128'(dbg_ack), 128'(0));
            checkOutput("dbg_rdata_hold", 128'(dbg_rdata), 128'(held_rdata));
        end
        if (dbg_done) begin
            ack_due  = 1'b1;
            ack_data = cur.rdata;
        end

        prev_bus_req = bus_req;

        if (cpu_done && cpu_q.size() > 0) begin
            cpu_q.delete(0);
            cpu_req = 1'b0;
        end
        if (ack_now && dbg_q.size() > 0) begin
            dbg_q.delete(0);
            dbg_req = 1'b0;
        end
        if (!cpu_req && cpu_q.size() > 0) begin
            r          = cpu_q[0];
            cpu_req    = 1'b1;
            cpu_we     = r.we;
            cpu_dmtype = r.dmtype;
            cpu_addr   = r.addr;
            cpu_wdata  = r.wdata;
        end
        if (!dbg_req && dbg_q.size() > 0) begin
            r         = dbg_q[0];
            dbg_req   = 1'b1;
            dbg_we    = r.we;
            dbg_addr  = r.addr;
            dbg_wdata = r.wdata;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int g0;

        applyReset();

        $display("[TB] cpu load alone, ready in first busy cycle");
        ready_delay = 0;
        applyStimulus(OWNER_CPU, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        waitIdle(20);

        $display("[TB] simultaneous cpu and dbg after reset");
        applyReset();
        ready_delay = 1;
        applyStimulus(OWNER_CPU, 1'b0, 3'b001, 32'h0000_0200, 32'h0);
        applyStimulus(OWNER_DBG, 1'b0, 3'b000, 32'h0000_0300, 32'h0);
        waitIdle(30);

        $display("[TB] both ports held, grants alternate");
        ready_delay = 0;
        applyStimulus(OWNER_CPU, 1'b1, 3'b010, 32'h0000_1000, 32'hA1A1_0001);
        applyStimulus(OWNER_DBG, 1'b0, 3'b000, 32'h0000_2000, 32'h0);
        applyStimulus(OWNER_CPU, 1'b0, 3'b100, 32'h0000_1004, 32'h0);
        applyStimulus(OWNER_DBG, 1'b1, 3'b000, 32'h0000_2004, 32'hB2B2_0002);
        waitIdle(40);

        $display("[TB] bus never ready, timeouts");
        ready_delay = 100;
        applyStimulus(OWNER_CPU, 1'b0, 3'b100, 32'h0000_0500, 32'h0);
        applyStimulus(OWNER_DBG, 1'b1, 3'b000, 32'h0000_0600, 32'hCAFE_F00D);
        waitIdle(40);

        $display("[TB] dbg write, ready in third busy cycle");
        ready_delay = 2;
        applyStimulus(OWNER_DBG, 1'b1, 3'b000, 32'h0000_0040, 32'h1234_5678);
        waitIdle(20);

        $display("[TB] ready in the cycle the timeout would fire");
        ready_delay = 3;
        applyStimulus(OWNER_CPU, 1'b1, 3'b001, 32'h0000_0044, 32'h5555_AAAA);
        applyStimulus(OWNER_DBG, 1'b0, 3'b000, 32'h0000_0048, 32'h0);
        waitIdle(40);

        $display("[TB] bus_ready while idle");
        @(negedge clk);
        #2;
        idle_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            checkOutput("idle_ready_req", 128'(bus_req), 128'(0));
        end
        idle_ready = 1'b0;

        $display("[TB] reset in second busy cycle");
        ready_delay = 100;
        g0 = grants;
        applyStimulus(OWNER_DBG, 1'b0, 3'b000, 32'h0000_0080, 32'h0);
        n = 0;
        while (grants == g0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("rst_grant", 128'(grants - g0), 128'(1));
        @(negedge clk);
        #2;
        rst        = 1'b1;
        abort_ok   = 1'b1;
        dbg_req    = 1'b0;
        dbg_q.delete();
        ack_due    = 1'b0;
        held_rdata = 32'h0;
        @(negedge clk);
        #3;
        checkOutput("rst_busreq", 128'(bus_req), 128'(0));
        rst      = 1'b0;
        abort_ok = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        ready_delay = 0;
        applyStimulus(OWNER_DBG, 1'b0, 3'b000, 32'h0000_0084, 32'h0);
        waitIdle(20);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
